// File: rtl/tamagotchi_event_hub.sv
// tamagotchi_event_hub: synchronises and debounces NUM_CH raw stimuli, qualifies
// each channel as a press (rising edge) or sustained-level source, and queues the
// resulting channel events in a show-ahead FIFO drained via valid/ready.
// Optional build macro TAMAGOTCHI_EVENT_HUB_TIMESTAMP_EN adds a prescaled tick
// counter whose value is stored with every event and presented on ev_time.
module tamagotchi_event_hub #(
  parameter int unsigned       NUM_CH          = 6,
  parameter int unsigned       DEBOUNCE_CYCLES = 250000,
  parameter logic [NUM_CH-1:0] LEVEL_MASK      = NUM_CH'(6'b110000),
  parameter int unsigned       HOLD_CYCLES     = 2500000,
  parameter int unsigned       FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             raw_in,
  input  logic                          ev_ready,
  input  logic                          ovf_clr,
  output logic                          ev_valid,
  output logic [$clog2(NUM_CH)-1:0]     ev_ch,
  output logic [NUM_CH-1:0]             deb_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef TAMAGOTCHI_EVENT_HUB_TIMESTAMP_EN
  output logic [15:0]                   ev_time,
`endif
  output logic                          ovf
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] deb_q, deb_d, deb_prev_q;
  logic [NUM_CH-1:0] fired_q, fired_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] qual_c, gnt_oh_c;
  logic [DEB_W-1:0]  deb_cnt_q  [NUM_CH];
  logic [DEB_W-1:0]  deb_cnt_d  [NUM_CH];
  logic [HOLD_W-1:0] hold_cnt_q [NUM_CH];
  logic [HOLD_W-1:0] hold_cnt_d [NUM_CH];
  logic [CH_W-1:0]   mem_q [FIFO_DEPTH];
  logic [CH_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              pop_c, push_c, full_c, ovf_set_c;
  logic [CH_W-1:0]   gnt_idx_c;

  // Debounce and per-channel event qualification.
  always_comb begin
    deb_d   = deb_q;
    fired_d = fired_q;
    qual_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      deb_cnt_d[i]  = '0;
      hold_cnt_d[i] = hold_cnt_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) deb_d[i] = ~deb_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
      if (LEVEL_MASK[i]) begin
        if (!deb_q[i]) begin
          hold_cnt_d[i] = '0;
          fired_d[i]    = 1'b0;
        end else if (!fired_q[i]) begin
          if (hold_cnt_q[i] == HOLD_W'(HOLD_CYCLES)) begin
            qual_c[i]  = 1'b1;
            fired_d[i] = 1'b1;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
          end
        end
      end else begin
        qual_c[i] = deb_q[i] & ~deb_prev_q[i];
      end
    end
  end

  // Lowest-index arbitration of pending events into the FIFO, plus overflow tracking.
  always_comb begin
    pop_c     = ev_valid && ev_ready;
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    push_c    = 1'b0;
    gnt_idx_c = '0;
    gnt_oh_c  = '0;
    if (!full_c || pop_c) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          push_c      = 1'b1;
          gnt_idx_c   = CH_W'(i);
          gnt_oh_c    = '0;
          gnt_oh_c[i] = 1'b1;
        end
      end
    end
    // A new event on a channel whose previous one is leaving this cycle is not lost.
    ovf_set_c = |(qual_c & pend_q & ~gnt_oh_c);
    pend_d    = (pend_q & ~gnt_oh_c) | qual_c;
    ovf_d     = ovf_q;
    if (ovf_clr)   ovf_d = 1'b0;
    if (ovf_set_c) ovf_d = 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = gnt_idx_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      fired_q    <= '0;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      fired_q    <= fired_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      mem_q      <= mem_d;
    end
  end

`ifdef TAMAGOTCHI_EVENT_HUB_TIMESTAMP_EN
  logic [DEB_W-1:0] pre_q, pre_d;
  logic [15:0]      ts_q, ts_d;
  logic [15:0]      ts_mem_q [FIFO_DEPTH];
  logic [15:0]      ts_mem_d [FIFO_DEPTH];

  // Prescaled tick counter and per-entry timestamp capture.
  always_comb begin
    pre_d    = pre_q + DEB_W'(1);
    ts_d     = ts_q;
    ts_mem_d = ts_mem_q;
    if (pre_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      pre_d = '0;
      ts_d  = ts_q + 16'(1);
    end
    if (push_c) ts_mem_d[wr_ptr_q] = ts_q;
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
      ts_q  <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) ts_mem_q[j] <= '0;
    end else begin
      pre_q    <= pre_d;
      ts_q     <= ts_d;
      ts_mem_q <= ts_mem_d;
    end
  end

  assign ev_time = ts_mem_q[rd_ptr_q];
`endif

  assign ev_valid   = (count_q != '0);
  assign ev_ch      = mem_q[rd_ptr_q];
  assign deb_state  = deb_q;
  assign fifo_count = count_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_tamagotchi_event_hub.sv
// Directed bench for tamagotchi_event_hub with a cycle-level reference model
// (queue-based FIFO, run-length debounce/hold tracking) checked every cycle.
module tb_tamagotchi_event_hub;
  localparam int NCH   = 6;
  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int DEPTH = 4;
  localparam logic [5:0] LMASK = 6'b110000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] raw_in = '0;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_ch;
  logic [5:0] deb_state;
  logic [2:0] fifo_count;
  logic       ovf;

  int vectors = 0;
  int errors  = 0;

  tamagotchi_event_hub #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .LEVEL_MASK(LMASK),
    .HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .ev_ready(ev_ready), .ovf_clr(ovf_clr),
    .ev_valid(ev_valid), .ev_ch(ev_ch), .deb_state(deb_state),
    .fifo_count(fifo_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_s1[NCH], m_s2[NCH], m_deb[NCH], m_debp[NCH], m_pend[NCH];
  int m_run[NCH], m_hi[NCH];
  int m_q[$];
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_pend[i] = 0;
      m_run[i] = 0; m_hi[i] = 0;
    end
    m_q.delete();
    m_ovf = 0;
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_step();
    bit qual[NCH];
    bit pop, acc, set;
    int g;
    if (!rst) begin
      model_reset();
      return;
    end
    pop = (m_q.size() > 0) && ev_ready;
    acc = (m_q.size() < DEPTH) || pop;
    g = -1;
    if (acc) for (int i = 0; i < NCH; i++) if (m_pend[i] && g < 0) g = i;
    for (int i = 0; i < NCH; i++) begin
      if (LMASK[i]) qual[i] = m_deb[i] && (m_hi[i] == HOLD);
      else          qual[i] = m_deb[i] && !m_debp[i];
    end
    for (int i = 0; i < NCH; i++) begin
      m_hi[i]   = m_deb[i] ? m_hi[i] + 1 : 0;
      m_debp[i] = m_deb[i];
      if (m_s2[i] == m_deb[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = !m_deb[i];
          m_run[i] = 0;
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw_in[i];
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 0;
    end
    set = 0;
    for (int i = 0; i < NCH; i++) if (qual[i]) begin
      if (m_pend[i]) set = 1;
      m_pend[i] = 1;
    end
    if (ovf_clr) m_ovf = 0;
    if (set) m_ovf = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic compare_all();
    logic [5:0] dexp;
    for (int i = 0; i < NCH; i++) dexp[i] = m_deb[i];
    check("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    if (m_q.size() > 0) check("ev_ch", 32'(ev_ch), 32'(m_q[0]));
    check("deb_state", 32'(deb_state), 32'(dexp));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic press(input int ch);
    raw_in[ch] = 1'b1;
    tick(8);
    raw_in[ch] = 1'b0;
    tick(8);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1;
    model_reset();
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    compare_all();
    tick(2);
    rst = 1'b1;
    tick(2);

    // Latency: press on ch0, valid 8 edges later
    raw_in[0] = 1'b1;
    tick(7);
    check("lat_early", 32'(ev_valid), 0);
    tick(1);
    check("lat_valid", 32'(ev_valid), 1);
    check("lat_ch", 32'(ev_ch), 0);
    check("lat_count", 32'(fifo_count), 1);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check("lat_pop_valid", 32'(ev_valid), 0);
    check("lat_pop_count", 32'(fifo_count), 0);
    raw_in[0] = 1'b0;
    tick(8);

    // Glitch shorter than the debounce window
    raw_in[1] = 1'b1;
    tick(3);
    raw_in[1] = 1'b0;
    tick(10);
    check("glitch_deb", 32'(deb_state[1]), 0);
    check("glitch_valid", 32'(ev_valid), 0);
    check("glitch_ovf", 32'(ovf), 0);

    // Simultaneous events serialise by priority
    raw_in[3] = 1'b1;
    raw_in[2] = 1'b1;
    tick(8);
    check("prio_first", 32'(ev_ch), 2);
    check("prio_cnt1", 32'(fifo_count), 1);
    tick(1);
    check("prio_cnt2", 32'(fifo_count), 2);
    ev_ready = 1'b1;
    tick(1);
    check("prio_second", 32'(ev_ch), 3);
    tick(1);
    ev_ready = 1'b0;
    check("prio_empty", 32'(fifo_count), 0);
    raw_in[3:2] = 2'b00;
    tick(8);

    // Level hold on ch4
    raw_in[4] = 1'b1;
    tick(15);
    check("lvl_early", 32'(ev_valid), 0);
    tick(1);
    check("lvl_valid", 32'(ev_valid), 1);
    check("lvl_ch", 32'(ev_ch), 4);
    tick(4);
    check("lvl_once", 32'(fifo_count), 1);
    raw_in[4] = 1'b0;
    tick(8);
    raw_in[4] = 1'b1;
    tick(16);
    check("lvl_rearm", 32'(fifo_count), 2);
    ev_ready = 1'b1;
    tick(2);
    ev_ready = 1'b0;
    raw_in[4] = 1'b0;
    tick(8);

    // Backpressure, coalescing overflow and drain order
    press(0);
    press(1);
    press(2);
    press(3);
    press(0);
    check("bp_full", 32'(fifo_count), 4);
    check("bp_no_ovf", 32'(ovf), 0);
    press(0);
    check("bp_ovf", 32'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 0);
    ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_ch", 32'(ev_ch), 32'(exp_order[k]));
      tick(1);
    end
    ev_ready = 1'b0;
    check("drain_empty", 32'(ev_valid), 0);

    // Asynchronous reset mid-burst
    raw_in[2:0] = 3'b111;
    tick(10);
    check("burst_count", 32'(fifo_count), 3);
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(ev_valid), 0);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_deb", 32'(deb_state), 0);
    check("arst_ch", 32'(ev_ch), 0);
    check("arst_ovf", 32'(ovf), 0);
    raw_in = '0;
    tick(3);
    rst = 1'b1;
    tick(20);
    check("post_rst_valid", 32'(ev_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tamagotchi_event_hub.md
# tamagotchi_event_hub

Parametrised stimulus front-end for the pet controller, replacing per-source button, sensor and tilt glue with one block. Each of NUM_CH raw inputs is synchronised and debounced. Each channel is then qualified as either a press (edge) source or a sustained-level source, and the resulting events are serialised into a FIFO. The behaviour FSM drains the FIFO through a valid/ready handshake, so simultaneous stimuli are never lost or merged silently.

## Interface
- NUM_CH, 6, number of stimulus channels (2..16)
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to change a debounced level (≥1)
- LEVEL_MASK, 6'b110000, bit i = 1: channel i is a level source (ultrasonic presence, tilt); 0: press source
- HOLD_CYCLES, 2500000, cycles a level channel must stay debounced-high before its event fires (≥1)
- FIFO_DEPTH, 8, event queue entries (power of two, ≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- raw_in  in  NUM_CH  asynchronous stimuli, active-high
- ev_ready  in  1  consumer accepts head event
- ovf_clr  in  1  single-cycle clear of ovf
- ev_valid  out  1  FIFO non-empty
- ev_ch  out  $clog2(NUM_CH)  channel index of head event
- deb_state  out  NUM_CH  debounced levels
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- ovf  out  1  sticky: event coalesced or lost

## Operation
- Reset (rst low, async): all sync flops, counters, pending bits and FIFO pointers clear. ev_valid=0, ev_ch=0, deb_state=0, fifo_count=0, ovf=0, timestamp counter=0.
- Per channel, two-flop synchroniser, then debounce counter:
  - The counter resets whenever the synchronised value equals deb_state[i], or changes.
  - deb_state[i] toggles when the counter reaches DEBOUNCE_CYCLES.
- Press channel: a debounced 0→1 produces one qualified event. A debounced release produces nothing.
- Level channel: a hold counter runs while deb_state[i]=1.
  - A qualified event fires when the counter reaches HOLD_CYCLES, once per assertion.
  - The channel re-arms only after deb_state[i] returns to 0.
- A qualified event sets pending[i]. If pending[i] is already 1, the event is coalesced and ovf sets.
- Arbiter: each cycle, if any pending bit is set and the FIFO can accept a write, the lowest-index pending channel is written and its bit cleared.
  - One write per cycle.
  - "Can accept" means not full, or full with a pop in the same cycle.
- FIFO full with no pop: pending bits hold; nothing is dropped except through coalescing.
- Pop: ev_valid && ev_ready advances the head. ev_ch is show-ahead, valid whenever ev_valid=1.
- ovf_clr clears ovf. If a set and a clear occur in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_count = writes − pops, range 0..FIFO_DEPTH.

## Timing
- Raw edge at cycle 0:
  - Synchronised at cycle 2.
  - deb_state flips at cycle 2+DEBOUNCE_CYCLES.
  - pending is set at +1.
  - FIFO write and ev_valid=1 at cycle 2+DEBOUNCE_CYCLES+2 (empty FIFO, no higher-priority pending).
- Level channel: event at the cycle deb_state rises +HOLD_CYCLES+2 under the same conditions.
- Glitch shorter than DEBOUNCE_CYCLES: no deb_state change, no event.
- Push and pop in the same cycle when full: both occur, fifo_count unchanged.
- Pop when empty: ignored.
- All outputs are registered except ev_valid and ev_ch, which are decoded from registered pointers and storage.
- Reset mid-operation: the queue and pending events are discarded. Outputs reach reset values asynchronously.

## Configuration
- TAMAGOTCHI_EVENT_HUB_TIMESTAMP_EN
  - Defined:
    - A 16-bit free-running cycle-prescaled tick counter (increments every DEBOUNCE_CYCLES clocks, wraps 0xFFFF→0).
    - The counter value is stored with each FIFO entry at write time.
    - Extra output ev_time (16 bits), valid with ev_ch, reset 0.
  - Undefined: no counter, no ev_time port, FIFO width $clog2(NUM_CH) only.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, FIFO_DEPTH=4, NUM_CH=6, LEVEL_MASK=6'b110000.
- Latency: raw_in[0] rises at cycle 0, ev_ready=0 → ev_valid=1, ev_ch=0 at cycle 8, fifo_count=1. Then ev_ready=1 for one cycle → ev_valid=0, count 0.
- Glitch rejection: raw_in[1] high for 3 cycles then low → deb_state[1] stays 0, no event, ovf=0.
- Simultaneous and priority: raw_in[3] and raw_in[2] rise in the same cycle → FIFO receives ch2 then ch3 on consecutive cycles.
- Level hold: raw_in[4] held high 20 cycles → exactly one event for ch4, at cycle 2+4+8+2=16. Low then high again → second event.
- Backpressure and overflow:
  - ev_ready=0, five press events on ch0..ch3 then ch0 again → fifo_count=4, pending[0]=1, ovf=0.
  - A sixth ch0 event → ovf=1.
  - ovf_clr → ovf=0.
  - Draining yields ch0,1,2,3,0.
- Async reset: rst low mid-burst with fifo_count=3 → all outputs 0 within the same cycle. After release, no stale events.
